// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the RV32I memory stage.
// Defines the funct3 load/store encodings, FSM states and the bubble instruction.
package mem_stage_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

  // Canonical NOP (add x0, x0, x0) presented by MEM/WB out of reset
  localparam logic [31:0] ResetInst = 32'h00000033;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

  // Halfword on an odd byte, or word not on a 4-byte boundary
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic is_half;
    logic is_word;
    is_half = (funct3[1:0] == 2'b01);
    is_word = (funct3[1:0] == 2'b10);
    return (is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane logic: store mask/replication and load lane select/extension.
module mem_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  store_mask,
  output logic [31:0] store_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    store_mask  = 4'b0000;
    store_wdata = store_data;
    case (funct3)
      F3Sb: begin
        store_mask  = 4'b0001 << addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      F3Sh: begin
        store_mask  = 4'b0011 << {addr_lo[1], 1'b0};
        store_wdata = {2{store_data[15:0]}};
      end
      F3Sw: begin
        store_mask  = 4'b1111;
        store_wdata = store_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte   = load_word[{addr_lo, 3'b000} +: 8];
    ld_half   = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (funct3)
      F3Lb:    load_data = {{24{ld_byte[7]}}, ld_byte};
      F3Lh:    load_data = {{16{ld_half[15]}}, ld_half};
      F3Lbu:   load_data = {24'h000000, ld_byte};
      F3Lhu:   load_data = {16'h0000, ld_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: data-memory handshake FSM, upstream stall and MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [2:0]  i_opsel,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  output logic        o_stall,
  output logic        o_dmem_req,
  input  logic        i_dmem_ready,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_vld,
  output logic        o_rd_wen,
  output logic [4:0]  o_rd_waddr,
  output logic [31:0] o_rd_wdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_trap
);

  mem_state_e  state_q, state_d;
  logic        mem_op;
  logic        trap_now;
  logic        access;
  logic        stall;
  logic        dmem_req;
  logic [31:0] load_data;

  assign mem_op = i_vld & (i_mem_read | i_mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_now = mem_op & is_misaligned(i_opsel, i_dmem_addr[1:0]);
`else
  assign trap_now = 1'b0;
`endif

  // A trapping access never reaches memory
  assign access = mem_op & ~trap_now;

  mem_lsu_align u_align (
    .addr_lo     (i_dmem_addr[1:0]),
    .funct3      (i_opsel),
    .store_data  (i_dmem_wdata),
    .load_word   (i_dmem_rdata),
    .store_mask  (o_dmem_mask),
    .store_wdata (o_dmem_wdata),
    .load_data   (load_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (access & i_mem_read & i_dmem_ready) state_d = StWait;
      StWait:  if (i_dmem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    case (state_q)
      StIdle: begin
        dmem_req = access;
        stall    = access & (i_mem_read | ~i_dmem_ready);
      end
      StWait: begin
        stall = ~i_dmem_rvalid;
      end
      default: ;
    endcase
  end

  assign o_stall     = stall & i_rst_n;
  assign o_dmem_req  = dmem_req & i_rst_n;
  assign o_dmem_ren  = o_dmem_req & i_mem_read;
  assign o_dmem_wen  = o_dmem_req & i_mem_write & ~i_mem_read;
  assign o_dmem_addr = {i_dmem_addr[31:2], 2'b00};

  // Stalled cycles insert a bubble so the held entry retires exactly once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld      <= 1'b0;
      o_rd_wen   <= 1'b0;
      o_rd_waddr <= 5'd0;
      o_rd_wdata <= 32'd0;
      o_inst     <= ResetInst;
      o_pc       <= 32'd0;
      o_nxt_pc   <= 32'd0;
      o_trap     <= 1'b0;
    end else if (stall) begin
      o_vld    <= 1'b0;
      o_rd_wen <= 1'b0;
      o_trap   <= 1'b0;
    end else begin
      o_vld      <= i_vld;
      o_rd_wen   <= i_vld & i_rd_wen & ~trap_now;
      o_rd_waddr <= i_rd_waddr;
      o_rd_wdata <= i_mem_reg ? load_data : i_res;
      o_inst     <= i_inst;
      o_pc       <= i_pc;
      o_nxt_pc   <= i_nxt_pc;
      o_trap     <= trap_now;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a retire scoreboard.
// Misalign behaviour checked according to MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

  logic        clk, rst_n, vld, mem_read, mem_write, mem_reg, rd_wen;
  logic [31:0] res, addr, wdata, inst, pc, nxt_pc, dmem_rdata;
  logic [2:0]  opsel;
  logic [4:0]  rd_waddr;
  logic        dmem_ready, dmem_rvalid;
  logic        o_stall, o_dmem_req, o_dmem_ren, o_dmem_wen, o_vld, o_rd_wen, o_trap;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_rd_wdata, o_inst, o_pc, o_nxt_pc;
  logic [3:0]  o_dmem_mask;
  logic [4:0]  o_rd_waddr;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] pc;
    logic [31:0] inst;
  } retire_t;

  retire_t sb[$];
  int total  = 0;
  int passed = 0;
  int failed = 0;

  mem_stage dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_vld         (vld),
    .i_res         (res),
    .i_dmem_addr   (addr),
    .i_dmem_wdata  (wdata),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_mem_reg     (mem_reg),
    .i_opsel       (opsel),
    .i_rd_waddr    (rd_waddr),
    .i_rd_wen      (rd_wen),
    .i_inst        (inst),
    .i_pc          (pc),
    .i_nxt_pc      (nxt_pc),
    .o_stall       (o_stall),
    .o_dmem_req    (o_dmem_req),
    .i_dmem_ready  (dmem_ready),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_ren    (o_dmem_ren),
    .o_dmem_wen    (o_dmem_wen),
    .o_dmem_wdata  (o_dmem_wdata),
    .o_dmem_mask   (o_dmem_mask),
    .i_dmem_rvalid (dmem_rvalid),
    .i_dmem_rdata  (dmem_rdata),
    .o_vld         (o_vld),
    .o_rd_wen      (o_rd_wen),
    .o_rd_waddr    (o_rd_waddr),
    .o_rd_wdata    (o_rd_wdata),
    .o_inst        (o_inst),
    .o_pc          (o_pc),
    .o_nxt_pc      (o_nxt_pc),
    .o_trap        (o_trap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then compare any retirement against the scoreboard
  task automatic tick();
    retire_t e;
    @(posedge clk);
    #1;
    if (o_vld === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", {31'd0, o_vld}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ret_wen", {31'd0, o_rd_wen}, {31'd0, e.wen});
        check("ret_waddr", {27'd0, o_rd_waddr}, {27'd0, e.waddr});
        check("ret_wdata", o_rd_wdata, e.wdata);
        check("ret_trap", {31'd0, o_trap}, {31'd0, e.trap});
        check("ret_pc", o_pc, e.pc);
        check("ret_inst", o_inst, e.inst);
      end
    end
  endtask

  task automatic idle_inputs();
    vld = 0; mem_read = 0; mem_write = 0; mem_reg = 0; rd_wen = 0;
    res = 0; addr = 0; wdata = 0; opsel = 0; rd_waddr = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rdx,
                       input logic [31:0] p);
    vld = 1; mem_read = rd; mem_write = wr; mem_reg = rd; opsel = f3;
    addr = a; wdata = d; rd_waddr = rdx; rd_wen = ~wr; res = 32'hC0DE_0000 | p;
    pc = p; nxt_pc = p + 4; inst = 32'h0000_0003 | {p[15:0], 16'h0};
  endtask

  // Load accepted immediately, rvalid after 'waits' empty WAIT cycles
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input int waits, input logic [31:0] exp);
    int stalls;
    retire_t e;
    stalls = 0;
    drive(1'b1, 1'b0, f3, a, 32'd0, 5'd7, 32'h400 + a);
    dmem_ready = 1;
    e = '{1'b1, 5'd7, exp, 1'b0, pc, inst};
    sb.push_back(e);
    #1;
    check({tag, "_req"}, {31'd0, o_dmem_req}, 32'd1);
    check({tag, "_ren"}, {31'd0, o_dmem_ren}, 32'd1);
    check({tag, "_addr"}, o_dmem_addr, {a[31:2], 2'b00});
    if (o_stall === 1'b1) stalls++;
    for (int i = 0; i < waits; i++) begin
      tick();
      dmem_ready = 0;
      #1;
      check({tag, "_wait_req"}, {31'd0, o_dmem_req}, 32'd0);
      if (o_stall === 1'b1) stalls++;
    end
    tick();
    dmem_ready = 0;
    dmem_rvalid = 1;
    dmem_rdata = word;
    #1;
    check({tag, "_rvalid_stall"}, {31'd0, o_stall}, 32'd0);
    check({tag, "_stall_cycles"}, stalls, 1 + waits);
    tick();
    idle_inputs();
  endtask

  initial begin
    retire_t e;
    idle_inputs();
    pc = 0; nxt_pc = 0; inst = 0;

    // Reset, with a load presented to confirm req/stall are forced low
    rst_n = 0;
    vld = 1; mem_read = 1; dmem_ready = 0;
    #12;
    check("rst_stall", {31'd0, o_stall}, 32'd0);
    check("rst_req", {31'd0, o_dmem_req}, 32'd0);
    check("rst_vld", {31'd0, o_vld}, 32'd0);
    check("rst_rd_wen", {31'd0, o_rd_wen}, 32'd0);
    check("rst_trap", {31'd0, o_trap}, 32'd0);
    check("rst_waddr", {27'd0, o_rd_waddr}, 32'd0);
    check("rst_wdata", o_rd_wdata, 32'd0);
    check("rst_inst", o_inst, 32'h0000_0033);
    check("rst_pc", o_pc, 32'd0);
    check("rst_nxt_pc", o_nxt_pc, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    tick();

    // ALU op, ready held low: retires next cycle with no request
    vld = 1; res = 32'h1234; rd_waddr = 5; rd_wen = 1; pc = 32'h100; inst = 32'h00A0_0293;
    nxt_pc = 32'h104;
    e = '{1'b1, 5'd5, 32'h1234, 1'b0, 32'h100, 32'h00A0_0293};
    sb.push_back(e);
    #1;
    check("alu_req", {31'd0, o_dmem_req}, 32'd0);
    check("alu_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("alu_vld", {31'd0, o_vld}, 32'd1);
    idle_inputs();

    // SB to 0x103 with ready
    drive(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 5'd0, 32'h200);
    dmem_ready = 1;
    e = '{1'b0, 5'd0, res, 1'b0, pc, inst};
    sb.push_back(e);
    #1;
    check("sb_addr", o_dmem_addr, 32'h100);
    check("sb_mask", {28'd0, o_dmem_mask}, 32'b1000);
    check("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
    check("sb_wen", {31'd0, o_dmem_wen}, 32'd1);
    check("sb_stall", {31'd0, o_stall}, 32'd0);
    tick();
    idle_inputs();

    // SH to 0x102 with ready low for two cycles
    drive(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 5'd0, 32'h300);
    e = '{1'b0, 5'd0, res, 1'b0, pc, inst};
    sb.push_back(e);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("sh_hold_stall", {31'd0, o_stall}, 32'd1);
      check("sh_hold_req", {31'd0, o_dmem_req}, 32'd1);
      check("sh_hold_mask", {28'd0, o_dmem_mask}, 32'b1100);
      check("sh_hold_wdata", o_dmem_wdata, 32'hBEEF_BEEF);
      check("sh_hold_addr", o_dmem_addr, 32'h100);
      tick();
      check("sh_bubble", {31'd0, o_vld}, 32'd0);
    end
    dmem_ready = 1;
    #1;
    check("sh_ready_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("sh_retire", {31'd0, o_vld}, 32'd1);
    idle_inputs();
    tick();
    check("sh_single_retire", {31'd0, o_vld}, 32'd0);

    // Loads from 0x202 / 0x203 of word 0x80010000
    do_load("lh", 3'b001, 32'h202, 32'h8001_0000, 3, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h202, 32'h8001_0000, 3, 32'h0000_8001);
    do_load("lb", 3'b000, 32'h203, 32'h8001_0000, 0, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h202, 32'h8001_0000, 1, 32'h0000_0001);
    do_load("lw", 3'b010, 32'h204, 32'h89AB_CDEF, 2, 32'h89AB_CDEF);

    // Async reset while a load is in WAIT; late rvalid must be ignored
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd9, 32'h500);
    dmem_ready = 1;
    tick();
    dmem_ready = 0;
    #1;
    check("wait_stall", {31'd0, o_stall}, 32'd1);
    rst_n = 0;
    #1;
    check("rst_wait_stall", {31'd0, o_stall}, 32'd0);
    check("rst_wait_req", {31'd0, o_dmem_req}, 32'd0);
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
    dmem_rvalid = 1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("late_rvalid_stall", {31'd0, o_stall}, 32'd0);
    tick();
    check("late_rvalid_vld", {31'd0, o_vld}, 32'd0);
    idle_inputs();

`ifdef MEM_MISALIGN_TRAP_EN
    drive(1'b1, 1'b0, 3'b010, 32'h001, 32'd0, 5'd3, 32'h600);
    dmem_ready = 1;
    e = '{1'b0, 5'd3, 32'd0, 1'b1, pc, inst};
    sb.push_back(e);
    #1;
    check("mis_req", {31'd0, o_dmem_req}, 32'd0);
    check("mis_stall", {31'd0, o_stall}, 32'd0);
    dmem_rdata = 32'd0;
    tick();
    check("mis_trap", {31'd0, o_trap}, 32'd1);
    idle_inputs();
`else
    do_load("lh_mis", 3'b001, 32'h203, 32'h8001_0000, 0, 32'hFFFF_8001);
    check("no_trap", {31'd0, o_trap}, 32'd0);
`endif

    tick();
    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
